// File: rtl/vector_sweep_sequencer_pkg.sv
// Shared types and constants for the vector sweep sequencer and its MISR.
package vector_sweep_sequencer_pkg;

  localparam int unsigned SIG_W = 16;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Signature seed loaded on reset and at every accepted start
  localparam logic [SIG_W-1:0] MISR_SEED = 16'hFFFF;

  // Feedback taps: bits 15, 13, 12 and 10 of the current signature
  localparam logic [SIG_W-1:0] MISR_TAPS = 16'hB400;

  // One MISR step: shift left, feed back the tap parity, fold in the data word
  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] sig,
                                                 input logic [SIG_W-1:0] data);
    return {sig[SIG_W-2:0], ^(sig & MISR_TAPS)} ^ data;
  endfunction

endpackage

// File: rtl/vector_sweep_sequencer_misr16.sv
// 16-bit multiple-input signature register with synchronous clear and enable.
module misr16
  import vector_sweep_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [SIG_W-1:0] data_in,
  output logic [SIG_W-1:0] sig
);

  // Clear has priority over a compression step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= MISR_SEED;
    end else if (clear) begin
      sig <= MISR_SEED;
    end else if (enable) begin
      sig <= misr_next(sig, data_in);
    end
  end

endmodule

// File: rtl/vector_sweep_sequencer.sv
// Drives every input vector into the datapath, captures results, and
// accumulates per-bit ones counts plus a MISR signature.
module vector_sweep_sequencer
  import vector_sweep_sequencer_pkg::*;
#(
  parameter int unsigned VEC_W         = 7,
  parameter int unsigned RES_W         = 2,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         mode,
  input  logic                         step,
  input  logic                         abort,
  output logic [VEC_W-1:0]             vec_out,
  input  logic [RES_W-1:0]             res_in,
  output logic                         busy,
  output logic                         done,
  output logic                         cap_valid,
  output logic [VEC_W-1:0]             cap_vec,
  output logic [RES_W-1:0]             cap_res,
  output logic [RES_W*(VEC_W+1)-1:0]   ones_cnt,
  output logic [SIG_W-1:0]             signature
);

  localparam int unsigned CNT_W = VEC_W + 1;
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] VEC_LAST    = {VEC_W{1'b1}};

  state_t           state;
  state_t           state_nxt;
  logic [SET_W-1:0] settle_cnt;
  logic [SET_W-1:0] settle_nxt;
  logic [VEC_W-1:0] vec_nxt;
  logic             step_mode;
  logic             step_mode_nxt;
  logic             clear_c;
  logic             capture_c;
  logic             busy_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, sweep-control and capture-strobe decode; abort overrides all
  always_comb begin
    state_nxt     = state;
    vec_nxt       = vec_out;
    settle_nxt    = settle_cnt;
    step_mode_nxt = step_mode;
    clear_c       = 1'b0;
    capture_c     = 1'b0;

    if (abort) begin
      state_nxt  = ST_IDLE;
      vec_nxt    = '0;
      settle_nxt = '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_nxt     = ST_APPLY;
            vec_nxt       = '0;
            settle_nxt    = '0;
            step_mode_nxt = mode;
            clear_c       = 1'b1;
          end
        end
        ST_APPLY: begin
          if (settle_cnt == SETTLE_LAST) begin
            state_nxt = ST_CAPTURE;
          end else begin
            settle_nxt = settle_cnt + SET_W'(1);
          end
        end
        ST_CAPTURE: begin
          capture_c = 1'b1;
          if (vec_out == VEC_LAST) begin
            state_nxt = ST_DONE;
          end else if (step_mode) begin
            state_nxt = ST_HOLD;
          end else begin
            state_nxt  = ST_APPLY;
            vec_nxt    = vec_out + VEC_W'(1);
            settle_nxt = '0;
          end
        end
        ST_HOLD: begin
          if (step) begin
            state_nxt  = ST_APPLY;
            vec_nxt    = vec_out + VEC_W'(1);
            settle_nxt = '0;
          end
        end
        default: begin
          state_nxt  = ST_IDLE;
          vec_nxt    = '0;
          settle_nxt = '0;
        end
      endcase
    end
  end

  assign busy_c = (state_nxt == ST_APPLY) || (state_nxt == ST_CAPTURE) ||
                  (state_nxt == ST_HOLD);

  // Sweep control and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_out    <= '0;
      settle_cnt <= '0;
      step_mode  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      vec_out    <= vec_nxt;
      settle_cnt <= settle_nxt;
      step_mode  <= step_mode_nxt;
      busy       <= busy_c;
      done       <= (state_nxt == ST_DONE);
    end
  end

  // Capture registers and per-bit ones counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid <= 1'b0;
      cap_vec   <= '0;
      cap_res   <= '0;
      ones_cnt  <= '0;
    end else begin
      cap_valid <= capture_c;
      if (capture_c) begin
        cap_vec <= vec_out;
        cap_res <= res_in;
        for (int i = 0; i < int'(RES_W); i++) begin
          ones_cnt[i*CNT_W +: CNT_W] <= ones_cnt[i*CNT_W +: CNT_W] + CNT_W'(res_in[i]);
        end
      end else if (clear_c) begin
        ones_cnt <= '0;
      end
    end
  end

  // Signature compression of each captured result
  misr16 u_misr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear_c),
    .enable  (capture_c),
    .data_in (SIG_W'(res_in)),
    .sig     (signature)
  );

endmodule
